// File: rtl/video_geometry_meter.sv
// Per-frame raster geometry meter: measures, qualifies over STABLE_FRAMES identical frames, publishes.
// Optional interlace tolerance (262/263-style alternation) under `VIDEO_GEOMETRY_INTERLACE_EN.
module video_geometry_meter #(
  parameter int unsigned STABLE_FRAMES = 3,
  parameter int unsigned TIMEOUT_LINES = 4095
) (
  input  logic        CLK_VIDEO,
  input  logic        RESET_N,
  input  logic        CE_PIXEL,
  input  logic        VGA_DE,
  input  logic        VGA_HS,
  input  logic        VGA_VS,
  output logic [11:0] HACTIVE,
  output logic [11:0] VACTIVE,
  output logic [11:0] HTOTAL,
  output logic [11:0] VTOTAL,
  output logic        VALID,
  output logic        CHANGED,
  output logic        INTERLACED
);

  localparam logic [11:0] CntMax = 12'hfff;

  typedef enum logic [1:0] {StSync, StAcquire, StLocked} state_e;

  logic        de_q, hs_q, vs_q, de_d, hs_d, vs_d;
  logic        de_fall, hs_rise, vs_rise, timeout;
  logic [11:0] hcnt_q, hcnt_d, htcnt_q, htcnt_d, lcnt_q, lcnt_d, acnt_q, acnt_d;
  logic [11:0] fw_q, fw_d, fht_q, fht_d;
  logic        fw_vld_q, fw_vld_d, fht_vld_q, fht_vld_d, hs_seen_q, hs_seen_d;
  logic        irr_q, irr_d, ovf_q, ovf_d;
  logic [11:0] cl_w, cl_acnt;
  logic        cl_good, cl_eq, lcnt_eq;
  logic [11:0] snap_w_q, snap_w_d, snap_a_q, snap_a_d, snap_ht_q, snap_ht_d, snap_l_q, snap_l_d;
  logic        snap_good_q, snap_good_d;
  state_e      state_q, state_d;
  logic [3:0]  match_q, match_d;
  logic        publish;
  logic [11:0] pub_vtot;
  logic [11:0] hact_q, hact_d, vact_q, vact_d, htot_q, htot_d, vtot_q, vtot_d;
  logic        valid_q, valid_d, changed_q, changed_d;
`ifdef VIDEO_GEOMETRY_INTERLACE_EN
  logic        il_q, il_d;
`endif

  assign de_fall = CE_PIXEL & de_q & ~VGA_DE;
  assign hs_rise = CE_PIXEL & VGA_HS & ~hs_q;
  assign vs_rise = CE_PIXEL & VGA_VS & ~vs_q;
  assign timeout = hs_rise & ~vs_rise & (32'(lcnt_q) >= TIMEOUT_LINES);

`ifdef VIDEO_GEOMETRY_INTERLACE_EN
  assign lcnt_eq  = (lcnt_q == snap_l_q) || (lcnt_q == snap_l_q + 12'd1) ||
                    (snap_l_q == lcnt_q + 12'd1);
  assign pub_vtot = (lcnt_q > snap_l_q) ? lcnt_q : snap_l_q;
`else
  assign lcnt_eq  = (lcnt_q == snap_l_q);
  assign pub_vtot = lcnt_q;
`endif

  // Raster measurement. DE-side events belong to the frame closing on a coincident VS edge,
  // HS-side events to the frame that opens with it.
  always_comb begin
    de_d      = de_q;
    hs_d      = hs_q;
    vs_d      = vs_q;
    hcnt_d    = hcnt_q;
    htcnt_d   = htcnt_q;
    lcnt_d    = lcnt_q;
    acnt_d    = acnt_q;
    fw_d      = fw_q;
    fw_vld_d  = fw_vld_q;
    fht_d     = fht_q;
    fht_vld_d = fht_vld_q;
    hs_seen_d = hs_seen_q;
    irr_d     = irr_q;
    ovf_d     = ovf_q;

    if (CE_PIXEL) begin
      de_d = VGA_DE;
      hs_d = VGA_HS;
      vs_d = VGA_VS;
    end

    if (CE_PIXEL && VGA_DE) begin
      if (hcnt_q == CntMax) ovf_d = 1'b1;
      else                  hcnt_d = hcnt_q + 12'd1;
    end
    if (de_fall) begin
      if (!fw_vld_q) begin
        fw_d     = hcnt_q;
        fw_vld_d = 1'b1;
      end else if (hcnt_q != fw_q) begin
        irr_d = 1'b1;
      end
      hcnt_d = '0;
      if (acnt_q == CntMax) ovf_d = 1'b1;
      else                  acnt_d = acnt_q + 12'd1;
    end

    cl_w    = fw_d;
    cl_acnt = acnt_d;
    cl_good = !irr_d && !ovf_d && (acnt_d != '0) && (lcnt_q != '0);

    if (vs_rise) begin
      hcnt_d    = '0;
      lcnt_d    = '0;
      acnt_d    = '0;
      fw_d      = '0;
      fw_vld_d  = 1'b0;
      fht_d     = '0;
      fht_vld_d = 1'b0;
      hs_seen_d = 1'b0;
      irr_d     = 1'b0;
      ovf_d     = 1'b0;
    end

    if (hs_rise) begin
      if (lcnt_d == CntMax) ovf_d = 1'b1;
      else                  lcnt_d = lcnt_d + 12'd1;
      // A period is only meaningful once this frame has seen a previous HS edge.
      if (hs_seen_d) begin
        if (htcnt_q == CntMax) ovf_d = 1'b1;
        if (!fht_vld_d) begin
          fht_d     = htcnt_q;
          fht_vld_d = 1'b1;
        end else if (htcnt_q != fht_d) begin
          irr_d = 1'b1;
        end
      end
      hs_seen_d = 1'b1;
      htcnt_d   = 12'd1;
    end else if (CE_PIXEL && (htcnt_q != CntMax)) begin
      htcnt_d = htcnt_q + 12'd1;
    end
  end

  assign cl_eq = snap_good_q && (cl_w == snap_w_q) && (cl_acnt == snap_a_q) &&
                 (fht_q == snap_ht_q) && lcnt_eq;

  // Qualification FSM and publishing.
  always_comb begin
    state_d     = state_q;
    match_d     = match_q;
    snap_w_d    = snap_w_q;
    snap_a_d    = snap_a_q;
    snap_ht_d   = snap_ht_q;
    snap_l_d    = snap_l_q;
    snap_good_d = snap_good_q;
    publish     = 1'b0;
    hact_d      = hact_q;
    vact_d      = vact_q;
    htot_d      = htot_q;
    vtot_d      = vtot_q;
    valid_d     = valid_q;
    changed_d   = 1'b0;
`ifdef VIDEO_GEOMETRY_INTERLACE_EN
    il_d        = il_q;
`endif

    if (vs_rise) begin
      snap_w_d    = cl_w;
      snap_a_d    = cl_acnt;
      snap_ht_d   = fht_q;
      snap_l_d    = lcnt_q;
      snap_good_d = cl_good;
      unique case (state_q)
        StSync: begin
          // The frame ending here started before we synchronised; never compare against it.
          state_d     = StAcquire;
          match_d     = '0;
          snap_good_d = 1'b0;
        end
        StAcquire: begin
          if (cl_good && cl_eq) begin
            match_d = match_q + 4'd1;
            if (32'(match_q) + 32'd1 >= STABLE_FRAMES - 32'd1) begin
              state_d = StLocked;
              publish = 1'b1;
            end
          end else begin
            match_d = '0;
          end
        end
        StLocked: begin
          if (!(cl_good && cl_eq)) begin
            state_d = StAcquire;
            match_d = '0;
            valid_d = 1'b0;
`ifdef VIDEO_GEOMETRY_INTERLACE_EN
            il_d    = 1'b0;
`endif
          end
        end
        default: state_d = StSync;
      endcase
    end else if (timeout) begin
      state_d = StSync;
      match_d = '0;
      valid_d = 1'b0;
`ifdef VIDEO_GEOMETRY_INTERLACE_EN
      il_d    = 1'b0;
`endif
    end

    if (publish) begin
      hact_d    = cl_w;
      vact_d    = cl_acnt;
      htot_d    = fht_q;
      vtot_d    = pub_vtot;
      valid_d   = 1'b1;
      changed_d = (hact_d != hact_q) || (vact_d != vact_q) ||
                  (htot_d != htot_q) || (vtot_d != vtot_q);
`ifdef VIDEO_GEOMETRY_INTERLACE_EN
      il_d      = (lcnt_q != snap_l_q);
`endif
    end
  end

  always_ff @(posedge CLK_VIDEO or negedge RESET_N) begin
    if (!RESET_N) begin
      de_q        <= 1'b0;
      hs_q        <= 1'b0;
      vs_q        <= 1'b0;
      hcnt_q      <= '0;
      htcnt_q     <= '0;
      lcnt_q      <= '0;
      acnt_q      <= '0;
      fw_q        <= '0;
      fw_vld_q    <= 1'b0;
      fht_q       <= '0;
      fht_vld_q   <= 1'b0;
      hs_seen_q   <= 1'b0;
      irr_q       <= 1'b0;
      ovf_q       <= 1'b0;
      snap_w_q    <= '0;
      snap_a_q    <= '0;
      snap_ht_q   <= '0;
      snap_l_q    <= '0;
      snap_good_q <= 1'b0;
      state_q     <= StSync;
      match_q     <= '0;
      hact_q      <= '0;
      vact_q      <= '0;
      htot_q      <= '0;
      vtot_q      <= '0;
      valid_q     <= 1'b0;
      changed_q   <= 1'b0;
`ifdef VIDEO_GEOMETRY_INTERLACE_EN
      il_q        <= 1'b0;
`endif
    end else begin
      de_q        <= de_d;
      hs_q        <= hs_d;
      vs_q        <= vs_d;
      hcnt_q      <= hcnt_d;
      htcnt_q     <= htcnt_d;
      lcnt_q      <= lcnt_d;
      acnt_q      <= acnt_d;
      fw_q        <= fw_d;
      fw_vld_q    <= fw_vld_d;
      fht_q       <= fht_d;
      fht_vld_q   <= fht_vld_d;
      hs_seen_q   <= hs_seen_d;
      irr_q       <= irr_d;
      ovf_q       <= ovf_d;
      snap_w_q    <= snap_w_d;
      snap_a_q    <= snap_a_d;
      snap_ht_q   <= snap_ht_d;
      snap_l_q    <= snap_l_d;
      snap_good_q <= snap_good_d;
      state_q     <= state_d;
      match_q     <= match_d;
      hact_q      <= hact_d;
      vact_q      <= vact_d;
      htot_q      <= htot_d;
      vtot_q      <= vtot_d;
      valid_q     <= valid_d;
      changed_q   <= changed_d;
`ifdef VIDEO_GEOMETRY_INTERLACE_EN
      il_q        <= il_d;
`endif
    end
  end

  assign HACTIVE = hact_q;
  assign VACTIVE = vact_q;
  assign HTOTAL  = htot_q;
  assign VTOTAL  = vtot_q;
  assign VALID   = valid_q;
  assign CHANGED = changed_q;
`ifdef VIDEO_GEOMETRY_INTERLACE_EN
  assign INTERLACED = il_q;
`else
  assign INTERLACED = 1'b0;
`endif

endmodule

// File: tb/tb_video_geometry_meter.sv
// Randomized raster bench for video_geometry_meter with a frame-level run-length reference model.
module tb_video_geometry_meter;

  localparam int StableFrames = 3;
  localparam int HStart       = 5;
  localparam int VStart       = 2;

  logic        clk = 1'b0, rst_n = 1'b0, ce = 1'b0, de = 1'b0, hs = 1'b0, vs = 1'b0;
  logic [11:0] hact, vact, htot, vtot;
  logic        valid, changed, interlaced;
  int          n_checks = 0;
  int          n_errors = 0;

  video_geometry_meter #(
    .STABLE_FRAMES(StableFrames),
    .TIMEOUT_LINES(4095)
  ) dut (
    .CLK_VIDEO (clk),
    .RESET_N   (rst_n),
    .CE_PIXEL  (ce),
    .VGA_DE    (de),
    .VGA_HS    (hs),
    .VGA_VS    (vs),
    .HACTIVE   (hact),
    .VACTIVE   (vact),
    .HTOTAL    (htot),
    .VTOTAL    (vtot),
    .VALID     (valid),
    .CHANGED   (changed),
    .INTERLACED(interlaced)
  );

  always #5 clk = ~clk;

  typedef struct { int w; int va; int ht; int vt; } geom_t;
  typedef struct { int w; int a; int ht; int l; bit good; } frame_t;

  // Reference model: length of the trailing run of consecutive good, matching frames.
  bit     m_synced;
  int     m_run;
  frame_t m_prev, m_last;
  int     e_h, e_v, e_ht, e_vt;
  bit     e_valid, e_chg, e_il;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic bit same_frame(frame_t a, frame_t b);
    bit l_ok;
    l_ok = (a.l == b.l);
`ifdef VIDEO_GEOMETRY_INTERLACE_EN
    if ((a.l - b.l == 1) || (b.l - a.l == 1)) l_ok = 1'b1;
`endif
    return (a.w == b.w) && (a.a == b.a) && (a.ht == b.ht) && l_ok;
  endfunction

  task automatic model_reset();
    m_synced = 1'b0;
    m_run    = 0;
    e_h = 0; e_v = 0; e_ht = 0; e_vt = 0;
    e_valid = 1'b0; e_chg = 1'b0; e_il = 1'b0;
  endtask

  task automatic model_timeout();
    m_synced = 1'b0;
    m_run    = 0;
    e_valid  = 1'b0;
    e_il     = 1'b0;
  endtask

  task automatic model_close(input frame_t f);
    int nvt;
    e_chg = 1'b0;
    if (!m_synced) begin
      m_synced = 1'b1;
      m_run    = 0;
    end else begin
      if (!f.good)                                m_run = 0;
      else if (m_run > 0 && same_frame(f, m_prev)) m_run++;
      else                                        m_run = 1;
      if (m_run == StableFrames) begin
        nvt     = (f.l > m_prev.l) ? f.l : m_prev.l;
        e_chg   = (e_h != f.w) || (e_v != f.a) || (e_ht != f.ht) || (e_vt != nvt);
        e_h     = f.w;
        e_v     = f.a;
        e_ht    = f.ht;
        e_vt    = nvt;
        e_valid = 1'b1;
        e_il    = (f.l != m_prev.l);
      end else if (m_run < StableFrames) begin
        e_valid = 1'b0;
        e_il    = 1'b0;
      end
      m_prev = f;
    end
  endtask

  task automatic check_outputs(input string tag);
    check_eq({tag, "_valid"}, valid, e_valid);
    check_eq({tag, "_hactive"}, hact, e_h);
    check_eq({tag, "_vactive"}, vact, e_v);
    check_eq({tag, "_htotal"}, htot, e_ht);
    check_eq({tag, "_vtotal"}, vtot, e_vt);
    check_eq({tag, "_interlaced"}, interlaced, e_il);
  endtask

  // One CE-qualified pixel; gap < 0 picks a random number of idle clocks first.
  task automatic pix(input bit d, input bit h, input bit v, input int gap);
    int g;
    g  = (gap < 0) ? int'($urandom_range(0, 2)) : gap;
    ce = 1'b0;
    repeat (g) begin
      @(posedge clk);
      #1;
    end
    ce = 1'b1; de = d; hs = h; vs = v;
    @(posedge clk);
    #1;
    ce = 1'b0;
  endtask

  task automatic send_frame(input geom_t g, input int bad_line, input int gap,
                            input int stop_line);
    frame_t f;
    for (int l = 0; l < stop_line; l++) begin
      int wl;
      wl = (l == bad_line) ? g.w - 1 : g.w;
      for (int p = 0; p < g.ht; p++) begin
        bit d;
        d = (l >= VStart) && (l < VStart + g.va) && (p >= HStart) && (p < HStart + wl);
        if (l == 0 && p == 0) begin
          check_eq("valid_before_vs", valid, e_valid);
          model_close(m_last);
        end
        pix(d, p < 3, l < 2, gap);
        if (l == 0 && p == 0) begin
          check_outputs("vs");
          check_eq("changed", changed, e_chg);
          @(posedge clk);
          #1;
          check_eq("changed_width", changed, 1'b0);
        end
      end
    end
    f.w    = g.w;
    f.a    = g.va;
    f.ht   = g.ht;
    f.l    = g.vt;
    f.good = (bad_line < 0);
    m_last = f;
  endtask

  function automatic geom_t rand_geom();
    geom_t g;
    g.ht = int'($urandom_range(14, 20));
    g.w  = int'($urandom_range(4, g.ht - HStart - 2));
    g.vt = int'($urandom_range(8, 12));
    g.va = int'($urandom_range(3, g.vt - 3));
    return g;
  endfunction

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    geom_t ga, gb, gc, gi, g;
    int    extra;
    model_reset();
    ga = rand_geom();
    gb = rand_geom();
    gb.ht = ga.ht;
    gb.w  = (ga.w == 4) ? 5 : ga.w - 1;
    gc = rand_geom();
    gi = rand_geom();
    gi.vt = (gi.vt > 11) ? 11 : gi.vt;

    repeat (3) @(posedge clk);
    #1;
    check_outputs("reset");
    check_eq("reset_changed", changed, 1'b0);
    rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;

    // Lock with CE every 4th clock; lock expected at the 4th VS edge.
    for (int i = 0; i < 5; i++) send_frame(ga, -1, 3, ga.vt);
    // Mode change.
    for (int i = 0; i < 5; i++) send_frame(gb, -1, -1, gb.vt);
    // One short line, then clean frames relock with identical values.
    send_frame(gb, VStart + 1, -1, gb.vt);
    for (int i = 0; i < 4; i++) send_frame(gb, -1, -1, gb.vt);

    // Asynchronous reset in the middle of a frame.
    send_frame(ga, -1, -1, 3);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_outputs("async_reset");
    check_eq("async_reset_changed", changed, 1'b0);
    @(posedge clk);
    #1;
    de = 1'b0; hs = 1'b0; vs = 1'b0;
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) send_frame(ga, -1, -1, ga.vt);

    // VS loss: lines continue; timeout on the HS edge that takes the line count past 4095.
    extra = 4096 - ga.vt;
    for (int k = 1; k <= extra; k++) begin
      if (k == extra) check_eq("valid_before_timeout", valid, e_valid);
      pix(1'b0, 1'b1, 1'b0, 0);
      if (k == extra) begin
        model_timeout();
        check_outputs("timeout");
      end
      pix(1'b0, 1'b0, 1'b0, 0);
      pix(1'b0, 1'b0, 1'b0, 0);
      pix(1'b0, 1'b0, 1'b0, 0);
    end

    // Resynchronise after timeout, then alternate line totals.
    for (int i = 0; i < 5; i++) send_frame(gc, -1, -1, gc.vt);
    for (int i = 0; i < 7; i++) begin
      g    = gi;
      g.vt = gi.vt + (i % 2);
      send_frame(g, -1, -1, g.vt);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
